serial_shift_sequencer: RTL

// - Sequential front end for the single-step serial byte shifter: latches a byte job, applies N one-bit

---
 rtl/shift_pkg.sv | 15 +
 rtl/serial_shift_step.sv | 27 ++
 rtl/serial_shift_sequencer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared types and constants for the serial shift sequencer and its single-step datapath.
// The `SHIFT_ROTATE_EN build option is handled in serial_shift_sequencer.sv.
package shift_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // dir encoding: which end the fill bit enters from.
    localparam logic DIR_LEFT_IN_LSB  = 1'b0;
    localparam logic DIR_RIGHT_IN_MSB = 1'b1;

endpackage

// File: rtl/serial_shift_step.sv
// Combinational single one-bit shift: (data, dir, fill) -> (next data, bit that leaves).
// out_bit depends only on data and dir, so a caller may feed it back as fill for rotation.
module serial_shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    input  logic             dir,
    input  logic             fill,
    output logic [WIDTH-1:0] next_data,
    output logic             out_bit
);

    always_comb begin
        next_data = data;
        out_bit   = 1'b0;
        if (dir == DIR_LEFT_IN_LSB) begin
            next_data = {data[WIDTH-2:0], fill};
            out_bit   = data[WIDTH-1];
        end else begin
            next_data = {fill, data[WIDTH-1:1]};
            out_bit   = data[0];
        end
    end

endmodule

// File: rtl/serial_shift_sequencer.sv
// Latches a byte job, applies one one-bit shift per clock, then presents the result.
// Build option: define SHIFT_ROTATE_EN to add in_rot (rotate instead of shifting in ser_in).
module serial_shift_sequencer
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_dir,
    input  logic [CNT_W-1:0] in_count,
`ifdef SHIFT_ROTATE_EN
    input  logic             in_rot,
`endif
    input  logic             ser_in,
    output logic             ser_out,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    // Handshake: a transfer happens on a rising edge where valid & ready are both high;
    // valid never depends on ready, and out_data is held while out_valid is high.

    localparam logic [CNT_W-1:0] WIDTH_CNT = CNT_W'(WIDTH);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] data_q;
    logic             dir_q;
    logic [CNT_W-1:0] rem_q;
    logic [CNT_W-1:0] count_clamped;
    logic [WIDTH-1:0] step_data;
    logic             step_out;
    logic             fill;
    logic             accept;

    assign accept        = in_valid & in_ready;
    assign count_clamped = (in_count > WIDTH_CNT) ? WIDTH_CNT : in_count;

`ifdef SHIFT_ROTATE_EN
    logic rot_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rot_q <= 1'b0;
        end else if (accept) begin
            rot_q <= in_rot;
        end
    end

    // Rotation recirculates the bit leaving the register; ser_in is ignored then.
    assign fill = rot_q ? step_out : ser_in;
`else
    assign fill = ser_in;
`endif

    serial_shift_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .data      (data_q),
        .dir       (dir_q),
        .fill      (fill),
        .next_data (step_data),
        .out_bit   (step_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = (count_clamped == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (rem_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            dir_q  <= 1'b0;
            rem_q  <= '0;
        end else if (accept) begin
            data_q <= in_data;
            dir_q  <= in_dir;
            rem_q  <= count_clamped;
        end else if (state_q == SHIFT) begin
            data_q <= step_data;
            rem_q  <= rem_q - CNT_W'(1);
        end
    end

    assign ser_out  = busy ? step_out : 1'b0;
    assign out_data = data_q;

endmodule
